// File: rtl/cp0_ext_if.sv
// CP0 bus between the M stage and coprocessor 0: MFC0/MTC0 access, exception inputs and redirect outputs.
interface cp0_ext_if #(
  parameter int NUM_HWINT = 6
) ();
  logic [4:0]           rd_addr;
  logic [31:0]          rd_data;
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [31:0]          wr_data;
  logic [31:0]          exc_pc;
  logic                 exc_bd;
  logic [4:0]           exc_code;
  logic [31:0]          exc_badvaddr;
  logic [NUM_HWINT-1:0] hw_int;
  logic                 eret;
  logic                 irq_take;
  logic [31:0]          epc_out;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, exc_pc, exc_bd, exc_code,
           exc_badvaddr, hw_int, eret,
    input  rd_data, irq_take, epc_out
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, exc_pc, exc_bd, exc_code,
           exc_badvaddr, hw_int, eret,
    output rd_data, irq_take, epc_out
  );
endinterface

// File: rtl/cp0_ext.sv
// Coprocessor 0 for the P7 pipeline: SR, Cause, EPC, BadVAddr, PRId with nested-exception protection.
// Define CP0_TIMER_EN to add the Count/Compare timer whose TI flag drives interrupt line IP[15].
module cp0_ext #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h1234_5678
) (
  input  logic       clk,
  input  logic       reset,
  cp0_ext_if.slave   bus
);

  localparam logic [5:0] HW_MASK = 6'((1 << NUM_HWINT) - 1);
`ifdef CP0_TIMER_EN
  localparam logic [5:0] IM_MASK = HW_MASK | 6'b10_0000;
`else
  localparam logic [5:0] IM_MASK = HW_MASK;
`endif

  // EXL is the only state: NORMAL runs user code, HANDLER blocks interrupts and freezes EPC/BD.
  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} exl_state_e;

  exl_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_q, ip_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bva_q, bva_d;

  logic [5:0]  hw_live;
  logic        ti_w;
  logic [31:0] count_rd, compare_rd;
  logic        exl, exc_take, int_req, take;
  logic        wr_sr, wr_epc;
  logic [31:0] pc_word;

  always_comb begin
    hw_live = '0;
    for (int i = 0; i < NUM_HWINT; i++) hw_live[i] = bus.hw_int[i];
  end

  assign exl      = (state_q == HANDLER);
  assign exc_take = (bus.exc_code != 5'd0);
  assign int_req  = (|((hw_live | {ti_w, 5'b0}) & im_q)) & ie_q & ~exl;
  assign take     = reset & (exc_take | int_req);
  assign wr_sr    = bus.wr_en && (bus.wr_addr == 5'd12);
  assign wr_epc   = bus.wr_en && (bus.wr_addr == 5'd14);
  assign pc_word  = bus.exc_pc & 32'hFFFF_FFFC;

  assign bus.irq_take = take;
  assign bus.epc_out  = epc_q;

  // MTC0 first, then eret, then the take: later assignments override earlier ones.
  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    ip_d    = hw_live;
    bd_d    = bd_q;
    code_d  = code_q;
    epc_d   = epc_q;
    bva_d   = bva_q;
    if (wr_sr) begin
      im_d    = bus.wr_data[15:10] & IM_MASK;
      state_d = bus.wr_data[1] ? HANDLER : NORMAL;
      ie_d    = bus.wr_data[0];
    end
    if (wr_epc) epc_d = bus.wr_data;
    if (bus.eret) begin
      state_d = NORMAL;
      bd_d    = 1'b0;
    end
    if (take) begin
      state_d = HANDLER;
      code_d  = exc_take ? bus.exc_code : 5'd0;
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) bva_d = bus.exc_badvaddr;
      if (!exl) begin
        bd_d  = bus.exc_bd;
        epc_d = bus.exc_bd ? pc_word - 32'd4 : pc_word;
      end else begin
        bd_d  = bd_q;
        epc_d = epc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      im_q    <= '0;
      ie_q    <= 1'b0;
      ip_q    <= '0;
      bd_q    <= 1'b0;
      code_q  <= '0;
      epc_q   <= '0;
      bva_q   <= '0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      bd_q    <= bd_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      bva_q   <= bva_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        wr_count, wr_compare;

  assign wr_count   = bus.wr_en && (bus.wr_addr == 5'd9);
  assign wr_compare = bus.wr_en && (bus.wr_addr == 5'd11);

  // TI fires on the edge Count reaches Compare; rewriting Compare acknowledges it.
  always_comb begin
    count_d   = wr_count ? bus.wr_data : count_q + 32'd1;
    compare_d = wr_compare ? bus.wr_data : compare_q;
    ti_d      = ti_q;
    if (wr_compare)                ti_d = 1'b0;
    else if (count_d == compare_q) ti_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign ti_w       = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti_w       = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  // MFC0 reads registered state only, so a same-cycle MTC0 is not visible yet.
  always_comb begin
    bus.rd_data = '0;
    case (bus.rd_addr)
      5'd8:    bus.rd_data = bva_q;
      5'd9:    bus.rd_data = count_rd;
      5'd11:   bus.rd_data = compare_rd;
      5'd12:   bus.rd_data = {16'b0, im_q, 8'b0, exl, ie_q};
      5'd13:   bus.rd_data = {bd_q, ti_w, 14'b0, ip_q | {ti_w, 5'b0}, 3'b0, code_q, 2'b0};
      5'd14:   bus.rd_data = epc_q;
      5'd15:   bus.rd_data = PRID_VAL;
      default: bus.rd_data = '0;
    endcase
  end

endmodule
